// File: rtl/pdm_decimator.sv
// 1-bit PDM to unsigned PCM converter: 3rd-order CIC (R = 2**DECIM_LOG2) feeding a one-entry valid/ready buffer.
// Optional input synchroniser enabled by defining PDM_DECIM_SYNC_EN.
module pdm_decimator #(
    parameter int DECIM_LOG2 = 4,
    parameter int OUT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pdm_ce,
    input  logic             pdm_in,
    output logic [OUT_W-1:0] pcm_data,
    output logic             pcm_valid,
    input  logic             pcm_ready,
    output logic             overrun
);
    localparam int YW = 3 * DECIM_LOG2;
    localparam int W  = YW + 1;
    localparam int SH = OUT_W - YW;

    logic                  w_bit;
    logic [W-1:0]          r_i1, r_i2, r_i3;
    logic [DECIM_LOG2-1:0] r_dcnt;
    logic                  w_event;
    logic                  r_ev1, r_ev2;
    logic [1:0]            r_prime;
    logic [W-1:0]          r_d1, r_d2, r_d3, r_y;
    logic [W-1:0]          w_c1, w_c2, w_c3;
    logic [YW-1:0]         w_sat;
    logic [OUT_W-1:0]      w_pcm;
    logic                  w_pop;
    logic [OUT_W-1:0]      r_pcm_data;
    logic                  r_pcm_valid;
    logic                  r_overrun;

`ifdef PDM_DECIM_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], pdm_in};
        end
    end

    assign w_bit = r_sync[1];
`else
    assign w_bit = pdm_in;
`endif

    // R is a power of two, so the counter wraps R-1 -> 0 on its own.
    assign w_event = pdm_ce & (r_dcnt == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i1   <= '0;
            r_i2   <= '0;
            r_i3   <= '0;
            r_dcnt <= '0;
        end else if (pdm_ce) begin
            r_i1   <= r_i1 + {{(W-1){1'b0}}, w_bit};
            r_i2   <= r_i2 + r_i1;
            r_i3   <= r_i3 + r_i2;
            r_dcnt <= r_dcnt + DECIM_LOG2'(1);
        end
    end

    assign w_c1 = r_i3 - r_d1;
    assign w_c2 = w_c1 - r_d2;
    assign w_c3 = w_c2 - r_d3;

    // The first three comb updates only build history; r_ev2 marks a usable result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ev1   <= 1'b0;
            r_ev2   <= 1'b0;
            r_prime <= 2'd0;
            r_d1    <= '0;
            r_d2    <= '0;
            r_d3    <= '0;
            r_y     <= '0;
        end else begin
            r_ev1 <= w_event;
            r_ev2 <= 1'b0;
            if (r_ev1) begin
                r_d1 <= r_i3;
                r_d2 <= w_c1;
                r_d3 <= w_c2;
                r_y  <= w_c3;
                if (r_prime == 2'd3) begin
                    r_ev2 <= 1'b1;
                end else begin
                    r_prime <= r_prime + 2'd1;
                end
            end
        end
    end

    // Full-scale DC gives exactly 2**YW, which does not fit in YW bits.
    assign w_sat = r_y[W-1] ? {YW{1'b1}} : r_y[YW-1:0];
    assign w_pcm = OUT_W'(w_sat) << SH;
    assign w_pop = r_pcm_valid & pcm_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcm_data  <= '0;
            r_pcm_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (r_ev2) begin
            if (!r_pcm_valid || w_pop) begin
                r_pcm_data  <= w_pcm;
                r_pcm_valid <= 1'b1;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (w_pop) begin
            r_pcm_valid <= 1'b0;
        end
    end

    assign pcm_data  = r_pcm_data;
    assign pcm_valid = r_pcm_valid;
    assign overrun   = r_overrun;
endmodule
